// File: rtl/pll_lock_ctrl.sv
// PLL40_CORE lock sequencer: drives RESETB/BYPASS/DYNAMICDELAY, qualifies LOCK,
// retries failed acquisitions and falls back to bypass when retries run out.
module pll_lock_ctrl #(
  parameter int unsigned  RESET_CYCLES   = 16,
  parameter int unsigned  LOCK_TIMEOUT   = 4096,
  parameter int unsigned  STABLE_CYCLES  = 256,
  parameter int unsigned  MAX_RETRIES    = 3,
  parameter int unsigned  SETTLE_CYCLES  = 64,
  parameter logic [7:0]   DELAY_INIT     = 8'h00,
  parameter bit           BYPASS_ON_FAIL = 1'b1,
  localparam int unsigned RETRY_W        = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               pll_lock,
  output logic               pll_resetb,
  output logic               pll_bypass,
  output logic [7:0]         pll_delay,
  input  logic               dly_valid,
  input  logic [7:0]         dly_data,
  output logic               dly_ready,
  output logic               clk_ok,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state
);

  localparam int unsigned MAX_RW   = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_SS   = (STABLE_CYCLES > SETTLE_CYCLES) ? STABLE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_CNT  = (MAX_RW > MAX_SS) ? MAX_RW : MAX_SS;
  localparam int unsigned CNT_W    = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   WAIT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STABLE = 3'd3,
    ST_RUN    = 3'd4,
    ST_SETTLE = 3'd5,
    ST_FAIL   = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic [7:0]         pll_delay_q, pll_delay_d;
  logic               pll_resetb_q, pll_resetb_d;
  logic               pll_bypass_q, pll_bypass_d;
  logic               dly_ready_q, dly_ready_d;
  logic               clk_ok_q, clk_ok_d;
  logic               fail_q, fail_d;
  logic               sync1_q, lock_s_q;
  logic               failed_attempt;
  logic               dly_accept;
  logic               timed_state;

  // Next-state selection; enable low overrides everything, including a pending delay accept.
  always_comb begin
    state_d        = state_q;
    failed_attempt = 1'b0;
    dly_accept     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RST;
      end
      ST_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lock_s_q)                state_d        = ST_STABLE;
        else if (cnt_q == WAIT_LAST) failed_attempt = 1'b1;
      end
      ST_STABLE: begin
        if (!lock_s_q)                 failed_attempt = 1'b1;
        else if (cnt_q == STABLE_LAST) state_d        = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          failed_attempt = 1'b1;
        end else if (dly_valid && dly_ready_q) begin
          dly_accept = 1'b1;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          if (lock_s_q) state_d        = ST_RUN;
          else          failed_attempt = 1'b1;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (failed_attempt) begin
      state_d = (retry_cnt_q == RETRY_MAX) ? ST_FAIL : ST_RST;
    end
    if (!enable) begin
      state_d    = ST_IDLE;
      dly_accept = 1'b0;
    end
  end

  // Shared timer: runs only in timed states, cleared whenever the state changes.
  always_comb begin
    timed_state = (state_q == ST_RST) || (state_q == ST_WAIT) ||
                  (state_q == ST_STABLE) || (state_q == ST_SETTLE);
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (timed_state)   cnt_d = cnt_q + CNT_W'(1);
  end

  // Retry bookkeeping and delay register.
  always_comb begin
    retry_cnt_d = retry_cnt_q;
    if ((state_d == ST_IDLE) || (state_d == ST_RUN)) begin
      retry_cnt_d = '0;
    end else if (failed_attempt && (retry_cnt_q != RETRY_MAX)) begin
      retry_cnt_d = retry_cnt_q + RETRY_W'(1);
    end

    pll_delay_d = pll_delay_q;
    if (dly_accept) pll_delay_d = dly_data;
  end

  // Outputs decoded from the next state so they are valid in the first cycle of each state.
  always_comb begin
    pll_resetb_d = 1'b0;
    pll_bypass_d = 1'b0;
    dly_ready_d  = 1'b0;
    clk_ok_d     = 1'b0;
    fail_d       = 1'b0;
    case (state_d)
      ST_WAIT, ST_STABLE, ST_SETTLE: begin
        pll_resetb_d = 1'b1;
      end
      ST_RUN: begin
        pll_resetb_d = 1'b1;
        dly_ready_d  = 1'b1;
        clk_ok_d     = 1'b1;
      end
      ST_FAIL: begin
        pll_bypass_d = BYPASS_ON_FAIL;
        fail_d       = 1'b1;
      end
      default: begin
        pll_resetb_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      lock_s_q     <= 1'b0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      retry_cnt_q  <= '0;
      pll_delay_q  <= DELAY_INIT;
      pll_resetb_q <= 1'b0;
      pll_bypass_q <= 1'b0;
      dly_ready_q  <= 1'b0;
      clk_ok_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      sync1_q      <= pll_lock;
      lock_s_q     <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      pll_delay_q  <= pll_delay_d;
      pll_resetb_q <= pll_resetb_d;
      pll_bypass_q <= pll_bypass_d;
      dly_ready_q  <= dly_ready_d;
      clk_ok_q     <= clk_ok_d;
      fail_q       <= fail_d;
    end
  end

  assign pll_resetb = pll_resetb_q;
  assign pll_bypass = pll_bypass_q;
  assign pll_delay  = pll_delay_q;
  assign dly_ready  = dly_ready_q;
  assign clk_ok     = clk_ok_q;
  assign fail       = fail_q;
  assign retry_cnt  = retry_cnt_q;
  assign state      = state_q;

endmodule
